esteira_render_param: RTL and testbench
=======================================

// Module: esteira_render_param
// PURPOSE
//  Parametrised conveyor-line pixel renderer that sits between vga_controller and the VGA pins.
//  It replaces fixed per-state sprites with frame-locked animation:
//  - a scrolling belt, driven by a sub-pixel-free offset counter;
//  - one bottle that travels with the belt across N filling/sealing stations;
//  - liquid rendered from a fill-level counter, plus a cap flag.
//  Two-stage pixel pipeline; sync outputs are delayed to match.
// PARAMETERS
//  H_ACTIVE        640  visible columns
//  V_ACTIVE        480  visible rows; frame tick when row first reaches this value
//  N_STATIONS      3    number of station nozzles drawn (1..8)
//  STATION_X0      94   left x of nozzle 0
//  STATION_PITCH   198  x distance between nozzles
//  NOZZLE_W        52   nozzle width; nozzle rows 131..173
//  BELT_Y0         320  first belt row
//  BELT_Y1         408  last belt row
//  STRIPE_LOG2     5    belt stripe period = 2**STRIPE_LOG2 px
//  STRIPE_W        16   light-stripe width within the period (< period)
//  SCROLL_STEP     2    px added to offset and bottle_x per step tick
//  FRAMES_PER_STEP 4    frame ticks per step tick (>=1)
//  BOTTLE_Y0       246  bottle top row; body ends at BELT_Y0-1
//  BOTTLE_W        36   bottle width
//  X_START         8    bottle x after reset/wrap
//  X_END           600  bottle_x >= X_END on a step tick -> wrap
//  CAP_H           8    cap rows directly above BOTTLE_Y0
// PORTS
//  pixel_clk       in   1   pixel clock (25 MHz)
//  reset_n         in   1   synchronous, active-low reset
//  disp_ena        in   1   active-video flag from vga_controller
//  h_sync, v_sync  in   1   syncs from vga_controller
//  column, row     in   32  current pixel coordinates
//  motor           in   1   1 = belt running
//  val_enchimento  in   1   1 = fill valve open
//  vedar           in   1   1-cycle pulse: cap applied
//  active_station  in   N_STATIONS  one-hot; highlights the nozzle
//  VGA_R/G/B       out  4   colour, reg
//  VGA_HS, VGA_VS  out  1   delayed syncs, reg
//  bottle_x        out  10  bottle left x, reg
//  fill_level      out  7   liquid height, px
//  bottle_done     out  1   1-cycle pulse on wrap
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all outputs 0 except bottle_x=X_START. Also clears:
//   - offset=0, frame_cnt=0, fill_level=0, cap_on=0
//   - both pipeline stages (syncs 0)
//  frame_tick: 1-cycle, row>=V_ACTIVE this cycle and row<V_ACTIVE previous cycle.
//  frame_cnt: counts frame_tick 0..FRAMES_PER_STEP-1 regardless of motor.
//   - step_tick = frame_tick && frame_cnt==FRAMES_PER_STEP-1
//  On step_tick with motor=1:
//   - offset <= (offset+SCROLL_STEP) mod 2**STRIPE_LOG2
//   - bottle_x <= bottle_x+SCROLL_STEP, unless bottle_x>=X_END
//   - wrap case: bottle_x<=X_START, fill_level<=0, cap_on<=0, bottle_done=1 next cycle
//  motor=0: offset and bottle_x frozen; fill/cap still update.
//  fill_level: +1 per frame_tick while val_enchimento=1.
//   - saturates at FILL_MAX = BELT_Y0-BOTTLE_Y0-4
//  cap_on: set by vedar.
//  Priority: wrap overrides a simultaneous fill increment or vedar in the same cycle.
//  State updates only on frame ticks, so a frame never tears mid-scan.
//  Stage 1 (registered hit flags, disp_ena, syncs):
//   - belt: row in [BELT_Y0,BELT_Y1], col<H_ACTIVE; light if ((col+offset) & (2**STRIPE_LOG2-1)) < STRIPE_W
//   - nozzle k: row 131..173, col in [STATION_X0+k*PITCH, +NOZZLE_W-1]
//   - body: col in [bottle_x, bottle_x+BOTTLE_W-1], row in [BOTTLE_Y0, BELT_Y0-1]
//   - liquid: fill_level>0, col inset 2, row in [BELT_Y0-2-fill_level, BELT_Y0-3]
//   - cap: cap_on, col inset 4, row in [BOTTLE_Y0-CAP_H, BOTTLE_Y0-1]
//  Stage 2: priority colour mux (R,G,B):
//   - liquid 15,0,0
//   - cap 10,9,6
//   - body 12,12,4
//   - active nozzle 4,12,4
//   - idle nozzle 12,12,12
//   - belt light 12,12,12
//   - belt dark 9,9,9
//   - else 0
//  Blanking: stage-1 disp_ena=0 -> RGB 0.
//  Latency: input pixel -> RGB/VGA_HS/VGA_VS exactly 2 pixel_clk cycles.
//  Arithmetic: coordinate compares in 11-bit unsigned; column/row upper bits must be 0 or the pixel is treated as off-screen.
//  Reset mid-frame: next pixels output black until the pipeline refills (2 cycles).
// TESTING
//  - Reset held 3 cycles with motor=1 -> RGB=0, syncs=0, bottle_x=8, fill=0, bottle_done=0.
//  - motor=1, 4 frames -> offset 2, bottle_x 10; at row 330:
//    - col 13 gives light (12); col 14 gives dark (9)
//    - col 30 gives light, since (30+2)&31=0
//  - val_enchimento=1 for 80 frames -> fill_level saturates at 70; liquid drawn at row 316 and row 248, not at row 247.
//  - bottle_x=600 at step_tick with vedar pulse same cycle -> bottle_x=8, cap_on=0, fill=0, one bottle_done pulse.
//  - active_station=3'b010, pixel (320,150) -> RGB 4,12,4 two cycles later; (120,150) -> 12,12,12.
//  - motor=0 for 10 frames -> offset and bottle_x unchanged; h_sync toggles reproduced on VGA_HS with exactly 2-cycle delay.

Source files
------------

// File: rtl/esteira_render_param.sv
// ----------------------------------------------------------------------------
// esteira_render_param
//
// Conveyor-line pixel renderer placed between a VGA timing generator and the
// VGA pins. Draws a scrolling belt, N station nozzles, and one bottle that
// rides the belt. The bottle shows a liquid column from a fill-level counter
// and an optional cap. Animation state changes only on frame ticks, so a
// visible frame never shows half-old, half-new geometry.
//
// Ports
//   pixel_clk        pixel clock
//   reset_n          synchronous active-low reset
//   disp_ena         active-video flag
//   h_sync, v_sync   syncs from the timing generator, delayed 2 cycles to pins
//   column, row      current pixel coordinates (32-bit)
//   motor            1 = belt running
//   val_enchimento   1 = fill valve open
//   vedar            1-cycle pulse, cap applied
//   active_station   one-hot nozzle highlight
//   VGA_R/G/B        4-bit colour, registered
//   VGA_HS, VGA_VS   delayed syncs, registered
//   bottle_x         bottle left x
//   fill_level       liquid height in pixels
//   bottle_done      1-cycle pulse when the bottle wraps back to the start
//
// Pipeline: stage 1 registers hit flags, disp_ena and syncs; stage 2
// registers the priority-muxed colour and the syncs. Input -> pins = 2 cycles.
// ----------------------------------------------------------------------------
module esteira_render_param #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int N_STATIONS      = 3,
    parameter int STATION_X0      = 94,
    parameter int STATION_PITCH   = 198,
    parameter int NOZZLE_W        = 52,
    parameter int BELT_Y0         = 320,
    parameter int BELT_Y1         = 408,
    parameter int STRIPE_LOG2     = 5,
    parameter int STRIPE_W        = 16,
    parameter int SCROLL_STEP     = 2,
    parameter int FRAMES_PER_STEP = 4,
    parameter int BOTTLE_Y0       = 246,
    parameter int BOTTLE_W        = 36,
    parameter int X_START         = 8,
    parameter int X_END           = 600,
    parameter int CAP_H           = 8
) (
    input  logic                  pixel_clk,
    input  logic                  reset_n,
    input  logic                  disp_ena,
    input  logic                  h_sync,
    input  logic                  v_sync,
    input  logic [31:0]           column,
    input  logic [31:0]           row,
    input  logic                  motor,
    input  logic                  val_enchimento,
    input  logic                  vedar,
    input  logic [N_STATIONS-1:0] active_station,
    output logic [3:0]            VGA_R,
    output logic [3:0]            VGA_G,
    output logic [3:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic [9:0]            bottle_x,
    output logic [6:0]            fill_level,
    output logic                  bottle_done
);

    // frame_cnt must be at least 1 bit wide even when FRAMES_PER_STEP == 1
    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FC_W-1:0]        FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [STRIPE_LOG2-1:0] OFF_STEP  = STRIPE_LOG2'(SCROLL_STEP);
    localparam logic [STRIPE_LOG2-1:0] STRIPE_WV = STRIPE_LOG2'(STRIPE_W);
    localparam logic [9:0]             X_STEP    = 10'(SCROLL_STEP);
    localparam logic [9:0]             X_STARTV  = 10'(X_START);
    localparam logic [9:0]             X_ENDV    = 10'(X_END);
    localparam logic [6:0]             FILL_MAX  = 7'(BELT_Y0 - BOTTLE_Y0 - 4);
    localparam logic [31:0]            V_ACTW    = 32'(V_ACTIVE);

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] BELT_TOP = 11'(BELT_Y0);
    localparam logic [10:0] BELT_BOT = 11'(BELT_Y1);
    localparam logic [10:0] NOZ_TOP  = 11'd131;
    localparam logic [10:0] NOZ_BOT  = 11'd173;
    localparam logic [10:0] BODY_TOP = 11'(BOTTLE_Y0);
    localparam logic [10:0] BODY_BOT = 11'(BELT_Y0 - 1);
    localparam logic [10:0] LIQ_BASE = 11'(BELT_Y0 - 2);
    localparam logic [10:0] LIQ_BOT  = 11'(BELT_Y0 - 3);
    localparam logic [10:0] CAP_TOP  = 11'(BOTTLE_Y0 - CAP_H);
    localparam logic [10:0] CAP_BOT  = 11'(BOTTLE_Y0 - 1);

    // ------------------------------------------------------------------
    // Frame-locked animation state
    // ------------------------------------------------------------------
    logic                   row_below_q;   // previous cycle had row < V_ACTIVE
    logic [FC_W-1:0]        frame_cnt;
    logic [STRIPE_LOG2-1:0] offset;
    logic                   cap_on;
    logic                   frame_tick;
    logic                   step_tick;
    logic                   wrap;

    assign frame_tick = (row >= V_ACTW) && row_below_q;
    assign step_tick  = frame_tick && (frame_cnt == FC_LAST);
    assign wrap       = step_tick && motor && (bottle_x >= X_ENDV);

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            row_below_q <= 1'b0;
            frame_cnt   <= '0;
            offset      <= '0;
            bottle_x    <= X_STARTV;
            fill_level  <= '0;
            cap_on      <= 1'b0;
            bottle_done <= 1'b0;
        end else begin
            row_below_q <= (row < V_ACTW);
            bottle_done <= 1'b0;

            if (frame_tick) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
            end

            if (step_tick && motor) begin
                offset <= offset + OFF_STEP;
                if (!wrap) begin
                    bottle_x <= bottle_x + X_STEP;
                end
            end

            // A wrap starts a fresh bottle and beats any same-cycle fill or cap
            if (wrap) begin
                bottle_x    <= X_STARTV;
                fill_level  <= '0;
                cap_on      <= 1'b0;
                bottle_done <= 1'b1;
            end else begin
                if (frame_tick && val_enchimento && (fill_level < FILL_MAX)) begin
                    fill_level <= fill_level + 7'd1;
                end
                if (vedar) begin
                    cap_on <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: geometry hit tests
    // ------------------------------------------------------------------
    logic                   on_screen;
    logic [10:0]            col;
    logic [10:0]            rw;
    logic [10:0]            bx;
    logic [10:0]            liq_top;
    logic [STRIPE_LOG2-1:0] stripe_pos;
    logic                   hit_belt;
    logic                   hit_light;
    logic                   hit_noz_act;
    logic                   hit_noz_idle;
    logic                   hit_body;
    logic                   hit_liquid;
    logic                   hit_cap;

    // Any set bit above the 11-bit coordinate range means off-screen
    assign on_screen  = (column[31:11] == 21'd0) && (row[31:11] == 21'd0);
    assign col        = column[10:0];
    assign rw         = row[10:0];
    assign bx         = {1'b0, bottle_x};
    assign liq_top    = LIQ_BASE - {4'b0000, fill_level};
    assign stripe_pos = col[STRIPE_LOG2-1:0] + offset;

    always_comb begin
        hit_belt     = 1'b0;
        hit_light    = 1'b0;
        hit_noz_act  = 1'b0;
        hit_noz_idle = 1'b0;
        hit_body     = 1'b0;
        hit_liquid   = 1'b0;
        hit_cap      = 1'b0;

        if (on_screen) begin
            if ((rw >= BELT_TOP) && (rw <= BELT_BOT) && (col < H_ACT)) begin
                hit_belt  = 1'b1;
                hit_light = (stripe_pos < STRIPE_WV);
            end

            if ((rw >= NOZ_TOP) && (rw <= NOZ_BOT)) begin
                for (int k = 0; k < N_STATIONS; k++) begin
                    if ((col >= 11'(STATION_X0 + k * STATION_PITCH)) &&
                        (col <= 11'(STATION_X0 + k * STATION_PITCH + NOZZLE_W - 1))) begin
                        if (active_station[k]) begin
                            hit_noz_act = 1'b1;
                        end else begin
                            hit_noz_idle = 1'b1;
                        end
                    end
                end
            end

            hit_body = (col >= bx) && (col <= bx + 11'(BOTTLE_W - 1)) &&
                       (rw >= BODY_TOP) && (rw <= BODY_BOT);

            hit_liquid = (fill_level != 7'd0) &&
                         (col >= bx + 11'd2) && (col <= bx + 11'(BOTTLE_W - 3)) &&
                         (rw >= liq_top) && (rw <= LIQ_BOT);

            hit_cap = cap_on &&
                      (col >= bx + 11'd4) && (col <= bx + 11'(BOTTLE_W - 5)) &&
                      (rw >= CAP_TOP) && (rw <= CAP_BOT);
        end
    end

    logic s1_ena, s1_hs, s1_vs;
    logic s1_liquid, s1_cap, s1_body, s1_noz_act, s1_noz_idle, s1_light, s1_dark;

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            s1_ena      <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_liquid   <= 1'b0;
            s1_cap      <= 1'b0;
            s1_body     <= 1'b0;
            s1_noz_act  <= 1'b0;
            s1_noz_idle <= 1'b0;
            s1_light    <= 1'b0;
            s1_dark     <= 1'b0;
        end else begin
            s1_ena      <= disp_ena;
            s1_hs       <= h_sync;
            s1_vs       <= v_sync;
            s1_liquid   <= hit_liquid;
            s1_cap      <= hit_cap;
            s1_body     <= hit_body;
            s1_noz_act  <= hit_noz_act;
            s1_noz_idle <= hit_noz_idle;
            s1_light    <= hit_belt && hit_light;
            s1_dark     <= hit_belt && !hit_light;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority colour mux and sync alignment
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            VGA_R  <= 4'd0;
            VGA_G  <= 4'd0;
            VGA_B  <= 4'd0;
            VGA_HS <= 1'b0;
            VGA_VS <= 1'b0;
        end else begin
            VGA_HS <= s1_hs;
            VGA_VS <= s1_vs;
            if (!s1_ena) begin
                {VGA_R, VGA_G, VGA_B} <= 12'h000;
            end else if (s1_liquid) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd15, 4'd0, 4'd0};
            end else if (s1_cap) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd10, 4'd9, 4'd6};
            end else if (s1_body) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd12, 4'd12, 4'd4};
            end else if (s1_noz_act) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd4, 4'd12, 4'd4};
            end else if (s1_noz_idle) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd12, 4'd12, 4'd12};
            end else if (s1_light) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd12, 4'd12, 4'd12};
            end else if (s1_dark) begin
                {VGA_R, VGA_G, VGA_B} <= {4'd9, 4'd9, 4'd9};
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_esteira_render_param.sv
// ----------------------------------------------------------------------------
// tb_esteira_render_param
//
// Directed bench for esteira_render_param with hand-computed expectations.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. Frame ticks are made by stepping row from 0 to 480.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_esteira_render_param;

    logic        pixel_clk;
    logic        reset_n;
    logic        disp_ena;
    logic        h_sync;
    logic        v_sync;
    logic [31:0] column;
    logic [31:0] row;
    logic        motor;
    logic        val_enchimento;
    logic        vedar;
    logic [2:0]  active_station;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [9:0]  bottle_x;
    logic [6:0]  fill_level;
    logic        bottle_done;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];

    esteira_render_param dut (
        .pixel_clk      (pixel_clk),
        .reset_n        (reset_n),
        .disp_ena       (disp_ena),
        .h_sync         (h_sync),
        .v_sync         (v_sync),
        .column         (column),
        .row            (row),
        .motor          (motor),
        .val_enchimento (val_enchimento),
        .vedar          (vedar),
        .active_station (active_station),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .bottle_x       (bottle_x),
        .fill_level     (fill_level),
        .bottle_done    (bottle_done)
    );

    // ---------------- clock / watchdog ----------------
    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive one pixel, then compare the colour two clocks later.
    task automatic pix(input string tag, input int c, input int r, input logic ena,
                       input logic [11:0] exp);
        @(negedge pixel_clk);
        column   = 32'(c);
        row      = 32'(r);
        disp_ena = ena;
        @(negedge pixel_clk);
        column   = 32'd0;
        row      = 32'd0;
        disp_ena = 1'b0;
        @(negedge pixel_clk);
        chk(tag, {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, exp});
    endtask

    // Each frame: one cycle with row 0, then one with row 480 (the tick).
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pixel_clk);
            row = 32'd0;
            @(negedge pixel_clk);
            row = 32'd480;
        end
        @(negedge pixel_clk);
        row = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         done_cnt;
        logic [15:0] hs_pat;
        logic [15:0] vs_pat;
        logic [1:0]  exp_sync;

        reset_n        = 1'b0;
        motor          = 1'b1;
        disp_ena       = 1'b1;
        h_sync         = 1'b1;
        v_sync         = 1'b1;
        column         = 32'd13;
        row            = 32'd330;
        val_enchimento = 1'b0;
        vedar          = 1'b0;
        active_station = 3'b000;

        // Reset held 3 cycles while inputs would otherwise draw a belt pixel
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("reset_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("reset_hs", {31'd0, VGA_HS}, 32'd0);
        chk("reset_vs", {31'd0, VGA_VS}, 32'd0);
        chk("reset_bottle_x", {22'd0, bottle_x}, 32'd8);
        chk("reset_fill", {25'd0, fill_level}, 32'd0);
        chk("reset_done", {31'd0, bottle_done}, 32'd0);

        reset_n  = 1'b1;
        disp_ena = 1'b0;
        h_sync   = 1'b0;
        v_sync   = 1'b0;
        column   = 32'd0;
        row      = 32'd0;

        // Running belt: 4 frames make one step -> offset 2, bottle_x 10
        frames(4);
        chk("step_bottle_x", {22'd0, bottle_x}, 32'd10);
        pix("belt_col13_light", 13, 330, 1'b1, 12'hCCC);
        pix("belt_col14_dark", 14, 330, 1'b1, 12'h999);
        pix("belt_col30_light", 30, 330, 1'b1, 12'hCCC);
        pix("belt_blanked", 13, 330, 1'b0, 12'h000);
        pix("belt_offscreen", 2048 + 13, 330, 1'b1, 12'h000);
        pix("belt_last_row", 14, 408, 1'b1, 12'h999);
        pix("below_belt", 14, 409, 1'b1, 12'h000);

        // Motor off: offset and bottle_x frozen
        motor = 1'b0;
        frames(10);
        chk("frozen_bottle_x", {22'd0, bottle_x}, 32'd10);
        chk("frozen_fill", {25'd0, fill_level}, 32'd0);
        pix("frozen_col13_light", 13, 330, 1'b1, 12'hCCC);
        pix("frozen_col14_dark", 14, 330, 1'b1, 12'h999);

        // Sync delay: every driven {h,v} must appear on the pins 2 cycles later
        hs_pat = 16'b0011_0101_1100_0110;
        vs_pat = 16'b1010_0110_0011_1001;
        exp_q  = {};
        for (int i = 0; i < 16; i++) begin
            @(negedge pixel_clk);
            if (exp_q.size() == 2) begin
                exp_sync = exp_q.pop_front();
                chk("sync_delay", {30'd0, VGA_HS, VGA_VS}, {30'd0, exp_sync});
            end
            h_sync = hs_pat[i];
            v_sync = vs_pat[i];
            exp_q.push_back({hs_pat[i], vs_pat[i]});
        end
        @(negedge pixel_clk);
        h_sync = 1'b0;
        v_sync = 1'b0;

        // Nozzles: station 1 active (x 292..343), station 0 idle (x 94..145)
        active_station = 3'b010;
        pix("noz_active", 320, 150, 1'b1, 12'h4C4);
        pix("noz_idle", 120, 150, 1'b1, 12'hCCC);
        pix("noz0_left_edge", 94, 150, 1'b1, 12'hCCC);
        pix("noz0_before", 93, 150, 1'b1, 12'h000);
        pix("noz0_after", 146, 150, 1'b1, 12'h000);
        pix("noz_below", 320, 174, 1'b1, 12'h000);
        pix("noz_top_row", 320, 131, 1'b1, 12'h4C4);

        // Filling: +1 per frame, saturating at 70
        val_enchimento = 1'b1;
        frames(10);
        chk("fill_10", {25'd0, fill_level}, 32'd10);
        frames(70);
        chk("fill_sat", {25'd0, fill_level}, 32'd70);
        val_enchimento = 1'b0;
        pix("liquid_row316", 12, 316, 1'b1, 12'hF00);
        pix("liquid_row248", 12, 248, 1'b1, 12'hF00);
        pix("body_row247", 12, 247, 1'b1, 12'hCC4);
        pix("body_inset_col11", 11, 300, 1'b1, 12'hCC4);
        pix("liquid_right_col43", 43, 300, 1'b1, 12'hF00);
        pix("body_right_col44", 44, 300, 1'b1, 12'hCC4);

        // Cap: vedar pulse, cap columns bottle_x+4..+31, rows 238..245
        pix("no_cap_yet", 14, 240, 1'b1, 12'h000);
        @(negedge pixel_clk);
        vedar = 1'b1;
        @(negedge pixel_clk);
        vedar = 1'b0;
        pix("cap_drawn", 14, 240, 1'b1, 12'hA96);
        pix("cap_inset_col13", 13, 240, 1'b1, 12'h000);

        // Run to bottle_x 600: frame phase is 2, so 2 + 294*4 frames = 295 steps
        motor = 1'b1;
        frames(1178);
        chk("at_x_end", {22'd0, bottle_x}, 32'd600);
        chk("fill_kept", {25'd0, fill_level}, 32'd70);
        pix("cap_at_600", 604, 240, 1'b1, 12'hA96);
        frames(3);
        chk("before_wrap", {22'd0, bottle_x}, 32'd600);

        // Wrapping step tick with a vedar pulse in the same cycle
        @(negedge pixel_clk);
        row = 32'd0;
        @(negedge pixel_clk);
        row   = 32'd480;
        vedar = 1'b1;
        @(negedge pixel_clk);
        chk("done_first", {31'd0, bottle_done}, 32'd1);
        done_cnt = int'(bottle_done);
        row   = 32'd0;
        vedar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pixel_clk);
            done_cnt += int'(bottle_done);
        end
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("wrap_bottle_x", {22'd0, bottle_x}, 32'd8);
        chk("wrap_fill", {25'd0, fill_level}, 32'd0);
        pix("wrap_no_cap", 12, 240, 1'b1, 12'h000);
        pix("wrap_no_liquid", 12, 300, 1'b1, 12'hCC4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
